// File: rtl/addon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addon_pkg
// Description : Shared definitions for the accumulate add-on controller:
//               FSM state encoding, bit positions of the control and status
//               fields on the uio bus, and the fixed uio output-enable value.
// Revision    : 1.0 - initial release
// ============================================================================
package addon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Control bits carried on uio_in
    localparam int UIO_OP_VALID = 0;
    localparam int UIO_OP_LAST  = 1;
    localparam int UIO_RES_ACK  = 2;
    localparam int UIO_SAT_MODE = 3;

    // Status bits driven on uio_out
    localparam int STAT_OP_READY  = 4;
    localparam int STAT_RES_VALID = 5;
    localparam int STAT_OVERFLOW  = 6;
    localparam int STAT_DROP_ERR  = 7;

    // Upper nibble of uio is output, lower nibble is input
    localparam logic [7:0] UIO_OE = 8'hF0;

endpackage : addon_pkg
`default_nettype wire

// File: rtl/addon_if.sv
`default_nettype none
// ============================================================================
// Module      : addon_if
// Description : Pad-side bus of the add-on controller.
//               ena     - design enable
//               ui_in   - 8-bit unsigned operand
//               uio_in  - control: op_valid, op_last, res_ack, sat_mode
//               uo_out  - result register
//               uio_out - status: op_ready, res_valid, overflow, drop_err
//               uio_oe  - uio direction (constant)
//               slave modport is the design side, master the driving side.
// Revision    : 1.0 - initial release
// ============================================================================
interface addon_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );
endinterface : addon_if
`default_nettype wire

// File: rtl/addon_adder8.sv
`default_nettype none
// ============================================================================
// Module      : addon_adder8
// Description : Combinational 8-bit adder with optional saturation.
//               a, b  - unsigned operands
//               sat   - 1: clamp to 8'hFF on carry, 0: wrap
//               sum   - 8-bit result (clamped or wrapped)
//               carry - carry-out of the 9-bit internal sum
// Revision    : 1.0 - initial release
// ============================================================================
module addon_adder8 (
    input  wire logic [7:0] a,
    input  wire logic [7:0] b,
    input  wire logic       sat,
    output logic      [7:0] sum,
    output logic            carry
);

    logic [8:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign carry  = w_full[8];
    assign sum    = (w_full[8] && sat) ? 8'hFF : w_full[7:0];

endmodule : addon_adder8
`default_nettype wire

// File: rtl/tt_um_addon_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_addon_ctrl
// Description : Streaming accumulator controller. Operands arriving on
//               ui_in are summed (wrap or saturate per operand) until one is
//               flagged last; the total is then presented on uo_out with
//               res_valid until acknowledged.
//               clk   - system clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - addon_if.slave (ena, ui_in, uio_in, uo_out,
//                       uio_out, uio_oe)
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_addon_ctrl
    import addon_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    addon_if.slave    bus
);

    state_t     r_state;
    logic [7:0] r_acc;
    logic [7:0] r_result;
    logic       r_overflow;
    logic       r_drop_err;
    // Set by every reset edge so op_ready stays low until reset is released
    logic       r_in_reset;

    logic       w_op_valid;
    logic       w_op_last;
    logic       w_res_ack;
    logic       w_sat_mode;
    logic       w_op_ready;
    logic       w_accept;
    logic [7:0] w_sum;
    logic       w_carry;
    logic       w_unused;

    assign w_op_valid = bus.uio_in[UIO_OP_VALID];
    assign w_op_last  = bus.uio_in[UIO_OP_LAST];
    assign w_res_ack  = bus.uio_in[UIO_RES_ACK];
    assign w_sat_mode = bus.uio_in[UIO_SAT_MODE];
    assign w_unused   = &{1'b0, bus.uio_in[7:4]};

    assign w_op_ready = bus.ena && !r_in_reset && (r_state != ST_DONE);
    assign w_accept   = w_op_valid && w_op_ready;

    addon_adder8 u_adder (
        .a     (r_acc),
        .b     (bus.ui_in),
        .sat   (w_sat_mode),
        .sum   (w_sum),
        .carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= 8'd0;
            r_result   <= 8'd0;
            r_overflow <= 1'b0;
            r_drop_err <= 1'b0;
            r_in_reset <= 1'b1;
        end else begin
            r_in_reset <= 1'b0;
            if (bus.ena) begin
                case (r_state)
                    ST_IDLE: begin
                        // First operand of a transaction loads directly;
                        // it also starts a fresh error/overflow record.
                        if (w_accept) begin
                            r_acc      <= bus.ui_in;
                            r_overflow <= 1'b0;
                            r_drop_err <= 1'b0;
                            if (w_op_last) begin
                                r_result <= bus.ui_in;
                                r_state  <= ST_DONE;
                            end else begin
                                r_state  <= ST_ACCUM;
                            end
                        end
                    end
                    ST_ACCUM: begin
                        if (w_accept) begin
                            r_acc <= w_sum;
                            if (w_carry) begin
                                r_overflow <= 1'b1;
                            end
                            if (w_op_last) begin
                                r_result <= w_sum;
                                r_state  <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Operands offered while the result is pending are
                        // lost; flag it even if the ack arrives together.
                        if (w_op_valid) begin
                            r_drop_err <= 1'b1;
                        end
                        if (w_res_ack) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.uio_out                 = 8'h00;
        bus.uio_out[STAT_OP_READY]  = w_op_ready;
        bus.uio_out[STAT_RES_VALID] = (r_state == ST_DONE);
        bus.uio_out[STAT_OVERFLOW]  = r_overflow;
        bus.uio_out[STAT_DROP_ERR]  = r_drop_err;
    end

    assign bus.uo_out = r_result;
    assign bus.uio_oe = UIO_OE;

endmodule : tt_um_addon_ctrl
`default_nettype wire

// File: tb/tb_tt_um_addon_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_addon_ctrl
// Description : Self-checking bench for tt_um_addon_ctrl. Directed scenarios
//               followed by randomized traffic, compared every cycle against
//               a transaction-level model (list of accepted operands folded
//               with plain integer arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_addon_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    addon_if bus ();

    tt_um_addon_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model
    bit         m_in_reset;
    bit         m_done;
    bit         m_in_txn;
    bit         m_ovf;
    bit         m_drop;
    logic [7:0] m_result;
    int         m_ops[$];
    bit         m_sats[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Sum the accepted operands in order; a carry clamps or wraps per operand
    task automatic fold(output int total, output bit ovf);
        total = 0;
        ovf   = 1'b0;
        foreach (m_ops[i]) begin
            total = total + m_ops[i];
            if (total > 255) begin
                ovf   = 1'b1;
                total = m_sats[i] ? 255 : total - 256;
            end
        end
    endtask

    task automatic model_edge(input bit en, input bit rn, input logic [7:0] op,
                              input bit v, input bit l, input bit a, input bit s);
        bit rdy;
        int total;
        bit ovf;
        if (!rn) begin
            m_in_reset = 1'b1;
            m_done     = 1'b0;
            m_in_txn   = 1'b0;
            m_ovf      = 1'b0;
            m_drop     = 1'b0;
            m_result   = 8'd0;
            m_ops.delete();
            m_sats.delete();
        end else begin
            rdy        = en && !m_in_reset && !m_done;
            m_in_reset = 1'b0;
            if (en) begin
                if (m_done) begin
                    if (v) m_drop = 1'b1;
                    if (a) m_done = 1'b0;
                end else if (v && rdy) begin
                    if (!m_in_txn) begin
                        m_ops.delete();
                        m_sats.delete();
                        m_drop   = 1'b0;
                        m_in_txn = 1'b1;
                    end
                    m_ops.push_back(int'(op));
                    m_sats.push_back(s);
                    fold(total, ovf);
                    m_ovf = ovf;
                    if (l) begin
                        m_result = total[7:0];
                        m_done   = 1'b1;
                        m_in_txn = 1'b0;
                    end
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs
    task automatic step(input bit en, input bit rn, input logic [7:0] op,
                        input bit v, input bit l, input bit a, input bit s);
        logic [7:0] exp_stat;
        bus.ena    = en;
        rst_n      = rn;
        bus.ui_in  = op;
        bus.uio_in = {4'b0000, s, a, l, v};
        @(posedge clk);
        #1;
        model_edge(en, rn, op, v, l, a, s);
        exp_stat = {m_drop, m_ovf, m_done, (en && !m_in_reset && !m_done), 4'b0000};
        chk("uo_out", bus.uo_out, m_result);
        chk("uio_out", bus.uio_out, exp_stat);
        chk("uio_oe", bus.uio_oe, 8'hF0);
    endtask

    initial begin
        // Reset, including with ena low
        step(0, 0, 8'd0, 0, 0, 0, 0);
        step(1, 0, 8'd0, 0, 0, 0, 0);
        chk("rst_uo", bus.uo_out, 8'd0);
        chk("rst_status", bus.uio_out, 8'h00);
        step(1, 1, 8'd0, 0, 0, 0, 0);
        chk("rel_ready", bus.uio_out, 8'h10);

        // 20 + 99
        step(1, 1, 8'd20, 1, 0, 0, 0);
        step(1, 1, 8'd99, 1, 1, 0, 0);
        chk("sum119", bus.uo_out, 8'd119);
        chk("sum119_stat", bus.uio_out, 8'h20);
        step(1, 1, 8'd0, 0, 0, 1, 0);
        chk("ack_idle", bus.uio_out, 8'h10);

        // 50 + 50, then overflow wrap and saturate
        step(1, 1, 8'd50, 1, 0, 0, 0);
        step(1, 1, 8'd50, 1, 1, 0, 0);
        chk("sum100", bus.uo_out, 8'd100);
        step(1, 1, 8'd0, 0, 0, 1, 0);
        step(1, 1, 8'd200, 1, 0, 0, 0);
        step(1, 1, 8'd100, 1, 1, 0, 0);
        chk("wrap44", bus.uo_out, 8'd44);
        chk("wrap_ovf", bus.uio_out[6], 1'b1);
        step(1, 1, 8'd0, 0, 0, 1, 0);
        chk("hold_after_ack", bus.uo_out, 8'd44);
        step(1, 1, 8'd200, 1, 0, 0, 1);
        step(1, 1, 8'd100, 1, 1, 0, 1);
        chk("sat255", bus.uo_out, 8'd255);
        chk("sat_ovf", bus.uio_out[6], 1'b1);
        step(1, 1, 8'd0, 0, 0, 1, 0);

        // Single operand transaction, then four operands
        step(1, 1, 8'd7, 1, 1, 0, 0);
        chk("single7", bus.uo_out, 8'd7);
        chk("single_ovf_clr", bus.uio_out, 8'h20);
        step(1, 1, 8'd0, 0, 0, 1, 0);
        step(1, 1, 8'd1, 1, 0, 0, 0);
        step(1, 1, 8'd2, 1, 0, 0, 0);
        step(1, 1, 8'd3, 1, 0, 0, 0);
        step(1, 1, 8'd4, 1, 1, 0, 0);
        chk("sum10", bus.uo_out, 8'd10);

        // Operand together with ack in DONE: dropped, flagged
        step(1, 1, 8'd9, 1, 0, 1, 0);
        chk("drop_uo", bus.uo_out, 8'd10);
        chk("drop_stat", bus.uio_out, 8'h90);
        step(1, 1, 8'd5, 1, 0, 0, 0);
        chk("drop_clr", bus.uio_out[7], 1'b0);

        // Idle/ignored controls in ACCUM, then reset mid-transaction
        step(1, 1, 8'd30, 1, 0, 0, 0);
        step(1, 1, 8'd0, 0, 1, 0, 0);
        step(1, 1, 8'd0, 0, 0, 1, 0);
        step(1, 1, 8'd40, 1, 0, 0, 0);
        step(1, 0, 8'd0, 0, 0, 0, 0);
        chk("mid_rst_uo", bus.uo_out, 8'd0);
        chk("mid_rst_stat", bus.uio_out, 8'h00);
        step(1, 1, 8'd0, 0, 0, 0, 0);
        chk("mid_rst_ready", bus.uio_out, 8'h10);

        // ena low mid-ACCUM holds everything
        step(1, 1, 8'd30, 1, 0, 0, 0);
        step(0, 1, 8'd40, 1, 1, 0, 0);
        chk("ena0_ready", bus.uio_out[4], 1'b0);
        step(0, 1, 8'd60, 1, 1, 1, 0);
        step(1, 1, 8'd5, 1, 1, 0, 0);
        chk("ena_hold35", bus.uo_out, 8'd35);
        step(1, 1, 8'd0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 49) != 0),
                 8'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tt_um_addon_ctrl
`default_nettype wire

// File: doc/tt_um_addon_ctrl.md
TT_UM_ADDON_CTRL -- requirements
Module: tt_um_addon_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port ena  input  1  design enable; when 0, FSM and registers hold and uio_out[4] reads 0.
REQ-004 SHALL have port ui_in  input  8  operand data, unsigned.
REQ-005 SHALL have port uio_in  input  8  control: [0] op_valid, [1] op_last, [2] res_ack, [3] sat_mode (1=saturate, 0=wrap), [7:4] unused.
REQ-006 SHALL have port uo_out  output  8  result register.
REQ-007 SHALL have port uio_out  output  8  status: [4] op_ready, [5] res_valid, [6] overflow, [7] drop_err, [3:0] = 0.
REQ-008 SHALL drive uio_oe to constant 8'hF0.

Function
REQ-009 SHALL implement FSM states IDLE, ACCUM, DONE; op_ready=1 in IDLE and ACCUM, 0 in DONE.
REQ-010 SHALL accept an operand on any cycle with ena=1, op_valid=1, op_ready=1.
REQ-011 Accept in IDLE: acc <= operand, overflow <= 0, drop_err <= 0; next state ACCUM, or DONE if op_last=1.
REQ-012 Accept in ACCUM: acc <= acc + operand via the shared 8-bit adder; next state DONE if op_last=1, else ACCUM.
REQ-013 Adder width: 9-bit internal sum; carry-out sets overflow (sticky within transaction).
REQ-014 Carry with sat_mode=1: acc <= 8'hFF; sat_mode=0: acc <= sum[7:0]; sat_mode sampled per accepted operand.
REQ-015 On transition into DONE, uo_out SHALL load the final accumulated value; latency: last operand accepted at edge N -> uo_out and res_valid valid after edge N (visible cycle N+1).
REQ-016 uo_out SHALL hold its value through DONE and after ack until the next DONE entry.
REQ-017 res_valid SHALL be 1 only in DONE; res_ack=1 in DONE returns FSM to IDLE next edge.
REQ-018 res_ack outside DONE SHALL be ignored.
REQ-019 op_valid=1 while in DONE SHALL not be accepted and SHALL set drop_err (sticky until next IDLE accept).
REQ-020 Simultaneous res_ack and op_valid in DONE: ack honoured, operand dropped, drop_err set.
REQ-021 op_valid=0 in ACCUM SHALL hold state and acc indefinitely (no timeout).
REQ-022 op_last with op_valid=0 SHALL be ignored.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force state IDLE, acc=0, uo_out=0, overflow=0, drop_err=0, regardless of ena or current state (including mid-ACCUM or DONE).
REQ-024 During reset uio_out[4] SHALL read 0 from the edge following reset assertion until release, then 1 in IDLE.

Structure
REQ-025 Package addon_pkg SHALL hold the state encoding, status bit indices, UIO_OE constant 8'hF0.
REQ-026 The adder SHALL be a sub-module addon_adder8 (a, b, sat -> sum[7:0], carry); controller owns all registers.
REQ-027 Implementation SHALL be fully synchronous, single clock domain, no latches.

Verification
REQ-028 Ops 20 (valid), 99 (valid+last), sat=0 -> uo_out=119, res_valid=1, overflow=0 one cycle after last; ack -> IDLE.
REQ-029 Ops 50, 50(last) -> uo_out=100; then ops 200, 100(last) sat=0 -> uo_out=44, overflow=1; repeat sat=1 -> uo_out=255, overflow=1.
REQ-030 Single op 7 with valid+last in IDLE -> DONE next cycle, uo_out=7; four ops 1,2,3,4(last) -> uo_out=10.
REQ-031 In DONE assert op_valid with value 9 and res_ack same cycle -> IDLE, drop_err=1, uo_out unchanged; next accept clears drop_err.
REQ-032 After ops 30, 40 in ACCUM, assert rst_n=0 one cycle -> uo_out=0, all status 0, op_ready=1 after release; ena=0 mid-ACCUM -> no accepts, acc held.
